mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter BIT_NUMBER, default 32, SHALL set the datapath width of alu_result, store data and load data.
REQ-002 Parameter DATA_BASE, default 1024, SHALL be the byte address of data-memory word 0.
REQ-003 Parameter DEPTH, default 64, SHALL be the number of data-memory words; DEPTH SHALL be a power of two and 2 <= DEPTH.
REQ-004 Ports SHALL be:
 clk  in  1  sole clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 mem_r_en  in  1  load from EXE
 mem_w_en  in  1  store from EXE
 wb_en_in  in  1  write-back enable from EXE
 dest_in  in  4  destination register from EXE
 alu_result  in  BIT_NUMBER  EXE result / byte address
 val_rm  in  BIT_NUMBER  store data
 sram_req  out  1  memory request
 sram_we  out  1  1 = write, 0 = read
 sram_addr  out  log2(DEPTH)  word address
 sram_wdata  out  BIT_NUMBER  write data
 sram_rdata  in  BIT_NUMBER  read data, valid with sram_ack
 sram_ack  in  1  request completion
 freeze  out  1  stall IF/ID/EXE
 wb_en_out  out  1  registered write-back enable
 mem_r_en_out  out  1  registered load flag
 dest_out  out  4  registered destination
 alu_result_out  out  BIT_NUMBER  registered ALU result
 mem_data_out  out  BIT_NUMBER  registered load data
 addr_err  out  1  sticky address error

Function
REQ-005 The FSM SHALL have states IDLE, ACCESS, DONE.
REQ-006 mem_op SHALL be defined as mem_r_en | mem_w_en; if both are asserted, the access SHALL be a write.
REQ-007 Address validity SHALL be: alu_result >= DATA_BASE, alu_result < DATA_BASE + 4*DEPTH, alu_result[1:0] == 0.
REQ-008 Word address SHALL be (alu_result - DATA_BASE) >> 2, truncated to log2(DEPTH) bits.
REQ-009 IDLE, mem_op=0: output register SHALL load the inputs at the next edge; mem_data_out SHALL be 0; FSM SHALL stay IDLE (single-cycle pass-through).
REQ-010 IDLE, mem_op=1, address valid: FSM SHALL go to ACCESS; sram_addr, sram_we and sram_wdata=val_rm SHALL be latched.
REQ-011 IDLE, mem_op=1, address invalid: FSM SHALL go to DONE without a request; addr_err SHALL set; captured data SHALL be 0.
REQ-012 ACCESS: sram_req SHALL be 1; sram_addr, sram_we and sram_wdata SHALL be stable until the ack cycle.
REQ-013 ACCESS with sram_ack=1: sram_rdata SHALL be captured if read, else 0 SHALL be captured; FSM SHALL go to DONE; sram_req SHALL be 0 from the next cycle.
REQ-014 ACCESS with sram_ack=0: FSM SHALL stay in ACCESS indefinitely; no timeout.
REQ-015 sram_ack outside ACCESS SHALL be ignored.
REQ-016 DONE: output register SHALL load the inputs with mem_data_out = captured data; FSM SHALL return to IDLE; the held mem_op SHALL NOT start a new access.
REQ-017 freeze SHALL be combinational: 1 in ACCESS; 1 in IDLE when mem_op=1; otherwise 0.
REQ-018 The output register SHALL hold its value while freeze=1.
REQ-019 Load latency SHALL be 2 + N cycles from presentation to output, where N is the number of ACCESS cycles before and including ack (ack on the first ACCESS cycle gives 3).
REQ-020 addr_err SHALL clear only on reset.
REQ-021 wb_en_out SHALL equal the wb_en_in captured on the load edge, for stores as well.

Reset
REQ-022 rst_n=0 SHALL asynchronously force: FSM to IDLE; sram_req, sram_we, wb_en_out, mem_r_en_out, addr_err to 0; sram_addr, sram_wdata, dest_out, alu_result_out, mem_data_out to 0.
REQ-023 While rst_n=0, freeze SHALL still follow REQ-017 combinationally, with state taken as IDLE.
REQ-024 Reset asserted in ACCESS SHALL abort the request; sram_req SHALL drop immediately; no output SHALL be loaded.
REQ-025 After rst_n deasserts, the first edge SHALL evaluate from IDLE.

Verification
REQ-026 ALU op, alu_result=0x55, wb_en_in=1, dest_in=3 -> next edge: alu_result_out=0x55, dest_out=3, freeze=0 throughout.
REQ-027 Load at 1032, ack on the 3rd ACCESS cycle, rdata=0xDEADBEEF -> sram_addr=2, sram_we=0, freeze high 4 cycles, mem_data_out=0xDEADBEEF, mem_r_en_out=1.
REQ-028 Store at 1024, val_rm=0x12345678, ack on the 1st ACCESS cycle -> sram_we=1, sram_addr=0, sram_wdata=0x12345678, sram_req high 1 cycle, freeze high 2 cycles.
REQ-029 Load at 1022 (unaligned), then at 1020 (below base), then at 1024+4*DEPTH -> no sram_req; addr_err=1 after the first; mem_data_out=0; one freeze cycle each.
REQ-030 rst_n low mid-ACCESS, then a stray sram_ack in IDLE -> all outputs 0, FSM IDLE, stray ack ignored.
REQ-031 mem_r_en=mem_w_en=1 at 1028 -> write performed, sram_addr=1.

Source files
------------

// File: rtl/mem_stage.sv
// Memory pipeline stage: forwards EXE results to write-back and, for loads
// and stores, runs a request/acknowledge handshake with an external word
// SRAM while stalling the front of the pipeline.
module mem_stage #(
   parameter int BIT_NUMBER = 32,
   parameter int DATA_BASE  = 1024,
   parameter int DEPTH      = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       mem_r_en,
   input  logic                       mem_w_en,
   input  logic                       wb_en_in,
   input  logic [3:0]                 dest_in,
   input  logic [BIT_NUMBER-1:0]      alu_result,
   input  logic [BIT_NUMBER-1:0]      val_rm,
   output logic                       sram_req,
   output logic                       sram_we,
   output logic [$clog2(DEPTH)-1:0]   sram_addr,
   output logic [BIT_NUMBER-1:0]      sram_wdata,
   input  logic [BIT_NUMBER-1:0]      sram_rdata,
   input  logic                       sram_ack,
   output logic                       freeze,
   output logic                       wb_en_out,
   output logic                       mem_r_en_out,
   output logic [3:0]                 dest_out,
   output logic [BIT_NUMBER-1:0]      alu_result_out,
   output logic [BIT_NUMBER-1:0]      mem_data_out,
   output logic                       addr_err
);

   localparam int AW = $clog2(DEPTH);

   // One extra bit so the upper window bound cannot wrap for addresses near
   // the top of the datapath range.
   localparam logic [BIT_NUMBER:0]   BASE_EXT  = (BIT_NUMBER+1)'(DATA_BASE);
   localparam logic [BIT_NUMBER:0]   LIMIT_EXT = (BIT_NUMBER+1)'(DATA_BASE + 4*DEPTH);
   localparam logic [BIT_NUMBER-1:0] BASE_N    = BIT_NUMBER'(DATA_BASE);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                state_q;
   logic [BIT_NUMBER-1:0] data_q;     // load data waiting for the DONE edge
   logic                  mem_op;
   logic                  addr_ok;
   logic [BIT_NUMBER-1:0] offset;
   logic [AW-1:0]         word_addr;

   assign mem_op    = mem_r_en | mem_w_en;
   assign addr_ok   = ({1'b0, alu_result} >= BASE_EXT) &&
                      ({1'b0, alu_result} <  LIMIT_EXT) &&
                      (alu_result[1:0] == 2'b00);
   assign offset    = alu_result - BASE_N;
   assign word_addr = AW'(offset >> 2);

   // Stall while a memory op waits in IDLE or the SRAM is busy; reset forces
   // state_q to IDLE so this keeps tracking mem_op during reset.
   assign freeze = (state_q == ACCESS) || ((state_q == IDLE) && mem_op);

   // Handshake FSM, SRAM request registers and the stage output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         data_q         <= '0;
         sram_req       <= 1'b0;
         sram_we        <= 1'b0;
         sram_addr      <= '0;
         sram_wdata     <= '0;
         wb_en_out      <= 1'b0;
         mem_r_en_out   <= 1'b0;
         dest_out       <= '0;
         alu_result_out <= '0;
         mem_data_out   <= '0;
         addr_err       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mem_op) begin
                  if (addr_ok) begin
                     // A store wins when both enables are set.
                     state_q    <= ACCESS;
                     sram_req   <= 1'b1;
                     sram_we    <= mem_w_en;
                     sram_addr  <= word_addr;
                     sram_wdata <= val_rm;
                  end else begin
                     // Out-of-window or unaligned: skip the SRAM entirely.
                     state_q  <= DONE;
                     addr_err <= 1'b1;
                     data_q   <= '0;
                  end
               end else begin
                  // Non-memory instruction passes straight through.
                  wb_en_out      <= wb_en_in;
                  mem_r_en_out   <= mem_r_en;
                  dest_out       <= dest_in;
                  alu_result_out <= alu_result;
                  mem_data_out   <= '0;
               end
            end
            ACCESS: begin
               // Wait as long as the SRAM needs; there is no timeout.
               if (sram_ack) begin
                  data_q   <= sram_we ? '0 : sram_rdata;
                  sram_req <= 1'b0;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               // Retire the held instruction; the still-asserted mem_op is
               // not re-issued because we return to IDLE unconditionally.
               wb_en_out      <= wb_en_in;
               mem_r_en_out   <= mem_r_en;
               dest_out       <= dest_in;
               alu_result_out <= alu_result;
               mem_data_out   <= data_q;
               state_q        <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized transactions,
// checked against a transaction-level model with a word memory array.
module tb_mem_stage;

   localparam int BW    = 32;
   localparam int BASE  = 1024;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          mem_r_en = 1'b0, mem_w_en = 1'b0, wb_en_in = 1'b0;
   logic [3:0]    dest_in = '0;
   logic [BW-1:0] alu_result = '0, val_rm = '0, sram_rdata = '0;
   logic          sram_ack = 1'b0;
   logic          sram_req, sram_we, freeze, wb_en_out, mem_r_en_out, addr_err;
   logic [AW-1:0] sram_addr;
   logic [BW-1:0] sram_wdata, alu_result_out, mem_data_out;
   logic [3:0]    dest_out;

   mem_stage #(.BIT_NUMBER(BW), .DATA_BASE(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en_in(wb_en_in),
      .dest_in(dest_in), .alu_result(alu_result), .val_rm(val_rm),
      .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ack(sram_ack),
      .freeze(freeze), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
      .dest_out(dest_out), .alu_result_out(alu_result_out),
      .mem_data_out(mem_data_out), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   logic [BW-1:0] mem_m [DEPTH];
   logic          err_m = 1'b0;
   logic [BW-1:0] prev_alu = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One instruction from presentation to retirement; starts just after a
   // rising edge with the DUT idle.
   task automatic txn(input logic r, input logic w, input logic wb, input logic [3:0] dest,
                      input logic [BW-1:0] alu, input logic [BW-1:0] rm, input int ack_n);
      logic          op, valid, done;
      int            word, fz, rq;
      logic [BW-1:0] exp_data;
      op       = r | w;
      valid    = (alu >= BASE) && (alu < BASE + 4*DEPTH) && ((alu % 4) == 0);
      word     = valid ? int'((alu - BASE) / 4) : 0;
      exp_data = (op && valid && !w) ? mem_m[word] : '0;
      mem_r_en = r; mem_w_en = w; wb_en_in = wb; dest_in = dest;
      alu_result = alu; val_rm = rm; sram_ack = 1'b0;
      fz = 0; rq = 0; done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         if (sram_req) begin
            rq++;
            chk("sram_addr", 64'(sram_addr), 64'(word));
            chk("sram_we", 64'(sram_we), 64'(w));
            chk("sram_wdata", 64'(sram_wdata), 64'(rm));
            sram_ack   = (rq == ack_n);
            sram_rdata = (rq == ack_n && !w) ? mem_m[word] : $urandom;
         end else begin
            // Stray acknowledges outside a request must be ignored.
            sram_ack   = 1'($urandom_range(0, 1));
            sram_rdata = $urandom;
         end
         if (freeze) begin
            fz++;
            chk("hold_alu_out", 64'(alu_result_out), 64'(prev_alu));
         end else begin
            done = 1'b1;
         end
      end
      checks++;
      assert (done) else begin
         errors++;
         $error("FAIL timeout observed=freeze_stuck expected=release");
      end
      @(posedge clk);
      #1;
      sram_ack = 1'b0;
      if (op && !valid) err_m = 1'b1;
      chk("alu_result_out", 64'(alu_result_out), 64'(alu));
      chk("dest_out", 64'(dest_out), 64'(dest));
      chk("wb_en_out", 64'(wb_en_out), 64'(wb));
      chk("mem_r_en_out", 64'(mem_r_en_out), 64'(r));
      chk("mem_data_out", 64'(mem_data_out), 64'(exp_data));
      chk("freeze_cycles", 64'(fz), 64'(op ? (valid ? 1 + ack_n : 1) : 0));
      chk("req_cycles", 64'(rq), 64'((op && valid) ? ack_n : 0));
      chk("req_after", 64'(sram_req), 64'(0));
      chk("addr_err", 64'(addr_err), 64'(err_m));
      if (op && valid && w) mem_m[word] = rm;
      prev_alu = alu;
      $display("txn r=%0d w=%0d alu=%h dest=%0d ack_n=%0d freeze=%0d req=%0d data=%h err=%0d",
               r, w, alu, dest, ack_n, fz, rq, mem_data_out, addr_err);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_req"}, 64'(sram_req), 64'(0));
      chk({tag, "_we"}, 64'(sram_we), 64'(0));
      chk({tag, "_addr"}, 64'(sram_addr), 64'(0));
      chk({tag, "_wdata"}, 64'(sram_wdata), 64'(0));
      chk({tag, "_wb"}, 64'(wb_en_out), 64'(0));
      chk({tag, "_mr"}, 64'(mem_r_en_out), 64'(0));
      chk({tag, "_dest"}, 64'(dest_out), 64'(0));
      chk({tag, "_alu"}, 64'(alu_result_out), 64'(0));
      chk({tag, "_data"}, 64'(mem_data_out), 64'(0));
      chk({tag, "_err"}, 64'(addr_err), 64'(0));
   endtask

   initial begin
      logic [BW-1:0] a;
      int            kind;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = $urandom;

      // Reset state, and freeze tracking mem_op while reset is held.
      #12;
      chk_zero_outputs("reset");
      chk("reset_freeze_idle", 64'(freeze), 64'(0));
      mem_r_en = 1'b1; #1;
      chk("reset_freeze_op", 64'(freeze), 64'(1));
      mem_r_en = 1'b0; #1;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // ALU pass-through.
      txn(1'b0, 1'b0, 1'b1, 4'd3, 32'h55, $urandom, 1);
      // Load at 1032 with the third ACCESS cycle acknowledging.
      mem_m[2] = 32'hDEADBEEF;
      txn(1'b1, 1'b0, 1'b1, 4'd5, 32'd1032, $urandom, 3);
      // Store at the base address, immediate ack.
      txn(1'b0, 1'b1, 1'b0, 4'd7, 32'd1024, 32'h12345678, 1);
      // Invalid addresses: unaligned, below base, one past the window.
      txn(1'b1, 1'b0, 1'b1, 4'd1, 32'd1022, $urandom, 1);
      txn(1'b1, 1'b0, 1'b1, 4'd2, 32'd1020, $urandom, 1);
      txn(1'b1, 1'b0, 1'b1, 4'd4, 32'(BASE + 4*DEPTH), $urandom, 1);
      // Both enables set: treated as a store, then read back.
      txn(1'b1, 1'b1, 1'b1, 4'd2, 32'd1028, $urandom, 2);
      txn(1'b1, 1'b0, 1'b1, 4'd6, 32'd1028, $urandom, 1);
      // Last word of the window.
      txn(1'b1, 1'b0, 1'b0, 4'd9, 32'(BASE + 4*DEPTH - 4), $urandom, 4);

      // Randomized mix.
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 5);
         a = 32'(BASE + 4*$urandom_range(0, DEPTH-1));
         case (kind)
            0: txn(1'b0, 1'b0, 1'($urandom), 4'($urandom), $urandom, $urandom, 1);
            1: txn(1'b1, 1'b0, 1'($urandom), 4'($urandom), a, $urandom, $urandom_range(1, 4));
            2: txn(1'b0, 1'b1, 1'($urandom), 4'($urandom), a, $urandom, $urandom_range(1, 4));
            3: txn(1'b1, 1'b1, 1'($urandom), 4'($urandom), a, $urandom, $urandom_range(1, 4));
            4: txn(1'b1, 1'b0, 1'($urandom), 4'($urandom), a + 32'($urandom_range(1, 3)), $urandom, 1);
            default: txn(1'($urandom), 1'b1, 1'($urandom), 4'($urandom),
                         32'(BASE - 4*$urandom_range(1, 200)), $urandom, 1);
         endcase
      end

      // Reset in the middle of an access, then a stray ack while idle.
      mem_r_en = 1'b1; mem_w_en = 1'b0; wb_en_in = 1'b1; dest_in = 4'd8;
      alu_result = 32'd1040; val_rm = $urandom; sram_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("req_before_reset", 64'(sram_req), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk_zero_outputs("midreset");
      chk("midreset_freeze", 64'(freeze), 64'(1));
      mem_r_en = 1'b0; wb_en_in = 1'b0; dest_in = '0; alu_result = '0; val_rm = '0;
      #1;
      chk("midreset_freeze_noop", 64'(freeze), 64'(0));
      @(negedge clk); rst_n = 1'b1; sram_ack = 1'b1; sram_rdata = $urandom;
      @(posedge clk); #1;
      sram_ack = 1'b0;
      chk_zero_outputs("stray_ack");
      chk("stray_ack_freeze", 64'(freeze), 64'(0));
      err_m = 1'b0; prev_alu = '0;

      // Normal operation resumes from IDLE.
      txn(1'b1, 1'b0, 1'b1, 4'd11, 32'd1032, $urandom, 2);
      txn(1'b0, 1'b0, 1'b1, 4'd12, 32'hCAFE0000, $urandom, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
